// File: rtl/ir_pkg.sv
// ir_pkg: IR timing constants shared by the transmit and receive paths, plus the transmit state type
package ir_pkg;
  localparam int IR_LEAD_MARK_TICKS = 1410;
  localparam int IR_MARK_TICKS = 141;
  localparam int IR_START_TICKS = 2003;
  localparam int IR_T0_TICKS = 441;
  localparam int IR_T1_TICKS = 891;
  localparam int IR_GAP_TICKS = 4000;
  localparam int IR_DATA_BITS = 32;
  typedef enum logic [2:0] {ST_IDLE, ST_LEAD, ST_SPACE, ST_MARK, ST_GAP} ir_tx_state_t;
  function automatic int ir_max(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ir_encoder_if.sv
// ir_encoder_if: request, timebase and line signals of the IR frame transmitter
interface ir_encoder_if;
  logic enable;
  logic start;
  logic [31:0] command;
  logic busy;
  logic done;
  logic ir_output;
  modport master(output enable, start, command, input busy, done, ir_output);
  modport slave(input enable, start, command, output busy, done, ir_output);
endinterface

// File: rtl/ir_tick_timer.sv
// ir_tick_timer: loadable down-counter that only moves on enable ticks and flags the terminal tick
module ir_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (enable && count != '0) count <= count - 1'b1;
  assign tc = enable && count == '0;
endmodule

// File: rtl/ir_encoder.sv
// ir_encoder: pulse-distance IR frame transmitter (leader, start symbol, 32 data symbols LSB first, gap)
module ir_encoder import ir_pkg::*; #(
  parameter int LEAD_MARK_TICKS = IR_LEAD_MARK_TICKS,
  parameter int MARK_TICKS = IR_MARK_TICKS,
  parameter int START_TICKS = IR_START_TICKS,
  parameter int T0_TICKS = IR_T0_TICKS,
  parameter int T1_TICKS = IR_T1_TICKS,
  parameter int GAP_TICKS = IR_GAP_TICKS
) (
  input logic clk,
  input logic rst,
  ir_encoder_if.slave bus
);
  localparam int MAX_T = ir_max(ir_max(LEAD_MARK_TICKS, START_TICKS), GAP_TICKS);
  localparam int W = $clog2(MAX_T) < 1 ? 1 : $clog2(MAX_T);
  localparam logic [5:0] LAST_IDX = 6'(IR_DATA_BITS + 1);
  if (LEAD_MARK_TICKS < 1 || MARK_TICKS < 1 || GAP_TICKS < 1 ||
      !(MARK_TICKS < T0_TICKS && T0_TICKS < T1_TICKS && T1_TICKS < START_TICKS)) begin : g_bad_params
    $error("ir_encoder: tick parameters must satisfy MARK < T0 < T1 < START and all >= 1");
  end
  ir_tx_state_t state;
  logic [31:0] sr, nxt_sr;
  logic [5:0] idx, nxt_idx;
  logic tc, accept, load;
  logic [W-1:0] load_val;
  int sym_period, phase_len;
  // Next-phase length is derived from the symbol that follows the current phase
  always_comb begin
    accept = state == ST_IDLE && bus.start && !bus.done;
    nxt_idx = state == ST_MARK ? idx + 6'd1 : idx;
    nxt_sr = state == ST_MARK && idx != 6'd0 ? sr >> 1 : sr;
    sym_period = nxt_idx == 6'd0 ? START_TICKS : nxt_sr[0] ? T1_TICKS : T0_TICKS;
    phase_len = state == ST_IDLE ? LEAD_MARK_TICKS :
                state == ST_SPACE ? MARK_TICKS :
                state == ST_MARK && nxt_idx == LAST_IDX ? GAP_TICKS :
                sym_period - MARK_TICKS;
    load = accept || (state != ST_IDLE && tc);
    load_val = W'(phase_len - 1);
  end
  ir_tick_timer #(.W(W)) u_timer (
    .clk(clk),
    .rst(rst),
    .enable(bus.enable),
    .load(load),
    .load_val(load_val),
    .tc(tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      sr <= '0;
      idx <= '0;
      bus.ir_output <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          sr <= bus.command;
          idx <= '0;
          state <= ST_LEAD;
          bus.ir_output <= 1'b0;
          bus.busy <= 1'b1;
        end
        ST_LEAD: if (tc) begin
          state <= ST_SPACE;
          bus.ir_output <= 1'b1;
        end
        ST_SPACE: if (tc) begin
          state <= ST_MARK;
          bus.ir_output <= 1'b0;
        end
        ST_MARK: if (tc) begin
          sr <= nxt_sr;
          idx <= nxt_idx;
          bus.ir_output <= 1'b1;
          state <= nxt_idx == LAST_IDX ? ST_GAP : ST_SPACE;
        end
        ST_GAP: if (tc) begin
          state <= ST_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule
